// File: rtl/mips_isa_pkg.sv
// Shared MIPS opcode/function codes and muldiv_unit state encoding.
package mips_isa_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;

  localparam logic [5:0] F_MFHI  = 6'b010000;
  localparam logic [5:0] F_MTHI  = 6'b010001;
  localparam logic [5:0] F_MFLO  = 6'b010010;
  localparam logic [5:0] F_MTLO  = 6'b010011;
  localparam logic [5:0] F_MULT  = 6'b011000;
  localparam logic [5:0] F_MULTU = 6'b011001;
  localparam logic [5:0] F_DIV   = 6'b011010;
  localparam logic [5:0] F_DIVU  = 6'b011011;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_FIX  = 2'd2;

endpackage

// File: rtl/muldiv_unit_if.sv
// Core-side instruction/operand bus of the multiply/divide unit.
interface muldiv_unit_if #(
  parameter int unsigned DATA_W = 32
);
  logic              i_valid;
  logic [5:0]        i_aluOp;
  logic [5:0]        i_func;
  logic [DATA_W-1:0] i_op1;
  logic [DATA_W-1:0] i_op2;
  logic              i_flush;
  logic              o_muldiv_op;
  logic              o_stall;
  logic              o_busy;
  logic [DATA_W-1:0] o_result;
  logic [DATA_W-1:0] o_hi;
  logic [DATA_W-1:0] o_lo;

  modport master (
    output i_valid, i_aluOp, i_func, i_op1, i_op2, i_flush,
    input  o_muldiv_op, o_stall, o_busy, o_result, o_hi, o_lo
  );

  modport slave (
    input  i_valid, i_aluOp, i_func, i_op1, i_op2, i_flush,
    output o_muldiv_op, o_stall, o_busy, o_result, o_hi, o_lo
  );
endinterface

// File: rtl/muldiv_core.sv
// Iterative radix-2 datapath: shift-add multiply, restoring divide, sign fix.
module muldiv_core #(
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic              step,
  input  logic              is_div,
  input  logic              is_signed,
  input  logic [DATA_W-1:0] op1,
  input  logic [DATA_W-1:0] op2,
  output logic              last,
  output logic [DATA_W-1:0] hi_res,
  output logic [DATA_W-1:0] lo_res
);
  localparam int unsigned CNT_W = $clog2(DATA_W) + 1;
  localparam int unsigned P_W   = 2 * DATA_W;

  logic [DATA_W-1:0] acc_q, quo_q, b_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              div_q, neg_q, neg_r_q, dz_q;
  logic              neg_a, neg_b;
  logic [DATA_W-1:0] abs_a, abs_b;
  logic [DATA_W:0]   mul_sum, shifted;
  logic [DATA_W+1:0] diff;
  logic              ge;
  logic [P_W-1:0]    prod, prod_fix;

  // Operand magnitudes; unsigned ops pass through untouched
  always_comb begin
    neg_a = is_signed & op1[DATA_W-1];
    neg_b = is_signed & op2[DATA_W-1];
    abs_a = neg_a ? -op1 : op1;
    abs_b = neg_b ? -op2 : op2;
  end

  // One iteration: multiply adds into acc and shifts right; divide shifts left and trial-subtracts
  always_comb begin
    mul_sum = {1'b0, acc_q} + (quo_q[0] ? {1'b0, b_q} : '0);
    shifted = {acc_q, quo_q[DATA_W-1]};
    diff    = {1'b0, shifted} - {2'b00, b_q};
    ge      = ~diff[DATA_W+1];
  end

  // Iteration registers; a zero divisor falls out as rem=|dividend|, quo=all ones
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q   <= '0;
      quo_q   <= '0;
      b_q     <= '0;
      cnt_q   <= '0;
      div_q   <= 1'b0;
      neg_q   <= 1'b0;
      neg_r_q <= 1'b0;
      dz_q    <= 1'b0;
    end else if (load) begin
      acc_q   <= '0;
      quo_q   <= abs_a;
      b_q     <= abs_b;
      cnt_q   <= '0;
      div_q   <= is_div;
      neg_q   <= neg_a ^ neg_b;
      neg_r_q <= neg_a;
      dz_q    <= is_div & (op2 == '0);
    end else if (step) begin
      cnt_q <= cnt_q + CNT_W'(1);
      if (div_q) begin
        acc_q <= ge ? diff[DATA_W-1:0] : shifted[DATA_W-1:0];
        quo_q <= {quo_q[DATA_W-2:0], ge};
      end else begin
        acc_q <= mul_sum[DATA_W:1];
        quo_q <= {mul_sum[0], quo_q[DATA_W-1:1]};
      end
    end
  end

  assign last = (cnt_q == CNT_W'(DATA_W - 1));

  // Sign correction of the final magnitude results
  always_comb begin
    prod     = {acc_q, quo_q};
    prod_fix = neg_q ? -prod : prod;
    hi_res   = prod_fix[P_W-1:DATA_W];
    lo_res   = prod_fix[DATA_W-1:0];
    if (div_q) begin
      hi_res = neg_r_q ? -acc_q : acc_q;
      lo_res = dz_q ? '1 : (neg_q ? -quo_q : quo_q);
    end
  end
endmodule

// File: rtl/muldiv_unit.sv
// Multiply/divide unit with HI/LO registers, decode and stall handshake.
module muldiv_unit #(
  parameter int unsigned DATA_W = 32
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  muldiv_unit_if.slave bus
);
  import mips_isa_pkg::*;

  logic [1:0]        state_q, state_d;
  logic [DATA_W-1:0] hi_q, lo_q, core_hi, core_lo, result_c;
  logic              busy_q, core_last, idle_c;
  logic              dec_any, dec_start, dec_signed, dec_div;
  logic              dec_mthi, dec_mtlo, dec_mfhi, dec_mflo;
  logic              load_c, step_c, fix_wr_c;

  // Instruction decode for the eight HI/LO instructions
  always_comb begin
    dec_start  = 1'b0;
    dec_signed = 1'b0;
    dec_div    = 1'b0;
    dec_mthi   = 1'b0;
    dec_mtlo   = 1'b0;
    dec_mfhi   = 1'b0;
    dec_mflo   = 1'b0;
    if (bus.i_aluOp == OP_RTYPE) begin
      case (bus.i_func)
        F_MFHI:  dec_mfhi = 1'b1;
        F_MTHI:  dec_mthi = 1'b1;
        F_MFLO:  dec_mflo = 1'b1;
        F_MTLO:  dec_mtlo = 1'b1;
        F_MULT:  begin dec_start = 1'b1; dec_signed = 1'b1; end
        F_MULTU: dec_start = 1'b1;
        F_DIV:   begin dec_start = 1'b1; dec_signed = 1'b1; dec_div = 1'b1; end
        F_DIVU:  begin dec_start = 1'b1; dec_div = 1'b1; end
        default: ;
      endcase
    end
    dec_any = dec_start | dec_mthi | dec_mtlo | dec_mfhi | dec_mflo;
  end

  assign idle_c = (state_q == S_IDLE);

  // Next state and datapath strobes; flush wins over start and suppresses the HI/LO write
  always_comb begin
    state_d  = state_q;
    load_c   = 1'b0;
    step_c   = 1'b0;
    fix_wr_c = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (bus.i_valid && dec_start && !bus.i_flush) begin
          state_d = S_RUN;
          load_c  = 1'b1;
        end
      end
      S_RUN: begin
        if (bus.i_flush) begin
          state_d = S_IDLE;
        end else begin
          step_c = 1'b1;
          if (core_last) state_d = S_FIX;
        end
      end
      S_FIX: begin
        state_d  = S_IDLE;
        fix_wr_c = !bus.i_flush;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State register with registered busy flag
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= S_IDLE;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      busy_q  <= (state_d != S_IDLE);
    end
  end

  // Architectural HI/LO: completion write or MTHI/MTLO while idle
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      hi_q <= '0;
      lo_q <= '0;
    end else if (fix_wr_c) begin
      hi_q <= core_hi;
      lo_q <= core_lo;
    end else if (idle_c && bus.i_valid) begin
      if (dec_mthi) hi_q <= bus.i_op1;
      if (dec_mtlo) lo_q <= bus.i_op1;
    end
  end

  // MFHI/MFLO read port, only live while idle
  always_comb begin
    result_c = '0;
    if (idle_c && bus.i_valid) begin
      if (dec_mfhi)      result_c = hi_q;
      else if (dec_mflo) result_c = lo_q;
    end
  end

  muldiv_core #(.DATA_W(DATA_W)) u_core (
    .clk       (i_clk),
    .rst_n     (i_rst_n),
    .load      (load_c),
    .step      (step_c),
    .is_div    (dec_div),
    .is_signed (dec_signed),
    .op1       (bus.i_op1),
    .op2       (bus.i_op2),
    .last      (core_last),
    .hi_res    (core_hi),
    .lo_res    (core_lo)
  );

  assign bus.o_muldiv_op = dec_any;
  assign bus.o_stall     = busy_q & bus.i_valid & dec_any;
  assign bus.o_busy      = busy_q;
  assign bus.o_result    = result_c;
  assign bus.o_hi        = hi_q;
  assign bus.o_lo        = lo_q;
endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit at DATA_W=32 and DATA_W=16.
module tb_muldiv_unit;
  import mips_isa_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_checks = 0;
  int   n_pass = 0;
  logic [63:0] sb_q[$];

  always #5 clk = ~clk;

  muldiv_unit_if #(.DATA_W(32)) bus32 ();
  muldiv_unit_if #(.DATA_W(16)) bus16 ();

  muldiv_unit #(.DATA_W(32)) u_dut32 (.i_clk(clk), .i_rst_n(rst_n), .bus(bus32.slave));
  muldiv_unit #(.DATA_W(16)) u_dut16 (.i_clk(clk), .i_rst_n(rst_n), .bus(bus16.slave));

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Reference result {HI,LO} for a 32-bit operation
  function automatic logic [63:0] model(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
    logic signed [63:0] pa, pb;
    logic signed [31:0] sa, sb, q, r;
    pa = {{32{a[31]}}, a};
    pb = {{32{b[31]}}, b};
    sa = a;
    sb = b;
    if (f == F_MULT)  return pa * pb;
    if (f == F_MULTU) return {32'b0, a} * {32'b0, b};
    if (b == 32'd0)   return {a, 32'hFFFF_FFFF};
    if (f == F_DIVU)  return {a % b, a / b};
    if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'd0, 32'h8000_0000};
    q = sa / sb;
    r = sa % sb;
    return {r, q};
  endfunction

  task automatic drive32(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
    bus32.i_valid = 1'b1;
    bus32.i_aluOp = OP_RTYPE;
    bus32.i_func  = f;
    bus32.i_op1   = a;
    bus32.i_op2   = b;
  endtask

  task automatic mt32(input logic [5:0] f, input logic [31:0] v);
    drive32(f, v, 32'd0);
    @(negedge clk);
    bus32.i_valid = 1'b0;
  endtask

  task automatic read32(input string tag, input logic [5:0] f, input logic [31:0] exp);
    drive32(f, 32'd0, 32'd0);
    #1 check(tag, bus32.o_result, exp);
    bus32.i_valid = 1'b0;
  endtask

  task automatic run_op(input string tag, input logic [5:0] f, input logic [31:0] a,
                        input logic [31:0] b, input logic [63:0] exp);
    int cyc;
    sb_q.push_back(exp);
    drive32(f, a, b);
    #1 check({tag, "_start_stall"}, bus32.o_stall, 0);
    @(negedge clk);
    bus32.i_valid = 1'b0;
    cyc = 0;
    while (bus32.o_busy && cyc < 200) begin
      cyc++;
      @(negedge clk);
    end
    check({tag, "_busy_cycles"}, cyc, 33);
    check({tag, "_hilo"}, {bus32.o_hi, bus32.o_lo}, sb_q.pop_front());
  endtask

  task automatic run16(input string tag, input logic [5:0] f, input logic [15:0] a,
                       input logic [15:0] b, input logic [31:0] exp);
    int cyc;
    sb_q.push_back({32'd0, exp});
    bus16.i_valid = 1'b1;
    bus16.i_aluOp = OP_RTYPE;
    bus16.i_func  = f;
    bus16.i_op1   = a;
    bus16.i_op2   = b;
    @(negedge clk);
    bus16.i_valid = 1'b0;
    cyc = 0;
    while (bus16.o_busy && cyc < 200) begin
      cyc++;
      @(negedge clk);
    end
    check({tag, "_busy_cycles"}, cyc, 17);
    check({tag, "_hilo"}, {32'd0, bus16.o_hi, bus16.o_lo}, sb_q.pop_front());
  endtask

  initial begin
    int cyc;
    logic [5:0]  f;
    logic [31:0] a, b;
    bus32.i_valid = 1'b0; bus32.i_aluOp = 6'h00; bus32.i_func = 6'h00;
    bus32.i_op1 = '0; bus32.i_op2 = '0; bus32.i_flush = 1'b0;
    bus16.i_valid = 1'b0; bus16.i_aluOp = 6'h00; bus16.i_func = 6'h00;
    bus16.i_op1 = '0; bus16.i_op2 = '0; bus16.i_flush = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    check("rst_hi", bus32.o_hi, 0);
    check("rst_lo", bus32.o_lo, 0);
    check("rst_busy", bus32.o_busy, 0);
    check("rst_stall", bus32.o_stall, 0);
    check("rst_result", bus32.o_result, 0);

    // Preload HI/LO, then reset in the middle of a multiply
    mt32(F_MTHI, 32'hAAAA_5555);
    mt32(F_MTLO, 32'h5555_AAAA);
    check("mthi", bus32.o_hi, 64'hAAAA_5555);
    check("mtlo", bus32.o_lo, 64'h5555_AAAA);
    drive32(F_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    @(negedge clk);
    bus32.i_valid = 1'b0;
    repeat (9) @(negedge clk);
    check("midop_busy", bus32.o_busy, 1);
    rst_n = 1'b0;
    #1;
    check("midrst_hi", bus32.o_hi, 0);
    check("midrst_lo", bus32.o_lo, 0);
    check("midrst_busy", bus32.o_busy, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("postrst_busy", bus32.o_busy, 0);
    drive32(F_MFLO, 32'd0, 32'd0);
    #1 check("postrst_stall", bus32.o_stall, 0);
    check("postrst_mflo", bus32.o_result, 0);
    bus32.i_valid = 1'b0;
    @(negedge clk);

    // Directed arithmetic cases
    run_op("mult_m3x7", F_MULT, 32'hFFFF_FFFD, 32'd7, 64'hFFFF_FFFF_FFFF_FFEB);
    read32("mfhi_mult", F_MFHI, 32'hFFFF_FFFF);
    read32("mflo_mult", F_MFLO, 32'hFFFF_FFEB);
    run_op("div_m7d2", F_DIV, 32'hFFFF_FFF9, 32'd2, {32'hFFFF_FFFF, 32'hFFFF_FFFD});
    run_op("divu_by0", F_DIVU, 32'd100, 32'd0, {32'd100, 32'hFFFF_FFFF});
    run_op("div_ovf", F_DIV, 32'h8000_0000, 32'hFFFF_FFFF, {32'd0, 32'h8000_0000});
    run_op("div_neg_by0", F_DIV, 32'hFFFF_FFFB, 32'd0, {32'hFFFF_FFFB, 32'hFFFF_FFFF});
    run_op("multu_max", F_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, {32'hFFFF_FFFE, 32'h0000_0001});
    run_op("mult_min", F_MULT, 32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000);

    // Random operations against the reference model
    for (int i = 0; i < 8; i++) begin
      f = F_MULT + 6'($urandom_range(0, 3));
      a = $urandom;
      b = (i % 2 == 0) ? 32'($urandom_range(1, 300)) : $urandom;
      if (i % 4 == 1) b = -b;
      run_op($sformatf("rand%0d", i), f, a, b, model(f, a, b));
    end

    // MFLO held behind a MULTU, with a non-muldiv op slipping through
    sb_q.push_back({32'd0, 32'd30});
    drive32(F_MULTU, 32'd5, 32'd6);
    @(negedge clk);
    drive32(F_MFLO, 32'd0, 32'd0);
    cyc = 0;
    #1;
    while (bus32.o_stall && cyc < 200) begin
      cyc++;
      if (cyc == 5) begin
        bus32.i_func = 6'b100000;
        #1 check("add_no_stall", bus32.o_stall, 0);
        check("add_not_muldiv", bus32.o_muldiv_op, 0);
        bus32.i_func = F_MFLO;
      end
      @(negedge clk);
      #1;
    end
    check("mflo_stall_cycles", cyc, 33);
    check("mflo_after_stall", bus32.o_result, 30);
    check("multu_5x6_hilo", {bus32.o_hi, bus32.o_lo}, sb_q.pop_front());
    bus32.i_valid = 1'b0;
    @(negedge clk);

    // Flush during a divide leaves HI/LO untouched
    mt32(F_MTHI, 32'h1234);
    mt32(F_MTLO, 32'h5678);
    drive32(F_DIV, 32'd100, 32'd7);
    @(negedge clk);
    bus32.i_valid = 1'b0;
    repeat (4) @(negedge clk);
    bus32.i_flush = 1'b1;
    @(negedge clk);
    bus32.i_flush = 1'b0;
    check("flush_busy", bus32.o_busy, 0);
    check("flush_hi", bus32.o_hi, 64'h1234);
    check("flush_lo", bus32.o_lo, 64'h5678);
    repeat (40) @(negedge clk);
    check("flush_hi_later", bus32.o_hi, 64'h1234);
    drive32(F_DIV, 32'd100, 32'd7);
    bus32.i_flush = 1'b1;
    @(negedge clk);
    bus32.i_valid = 1'b0;
    bus32.i_flush = 1'b0;
    check("flush_beats_start", bus32.o_busy, 0);
    run_op("divu_100_7", F_DIVU, 32'd100, 32'd7, {32'd2, 32'd14});

    // Decode boundaries
    bus32.i_aluOp = OP_RTYPE; bus32.i_func = F_MTLO;
    #1 check("dec_mtlo", bus32.o_muldiv_op, 1);
    bus32.i_aluOp = 6'h23; bus32.i_func = F_MULT;
    #1 check("dec_non_rtype", bus32.o_muldiv_op, 0);
    bus32.i_aluOp = OP_RTYPE; bus32.i_func = 6'b011100;
    #1 check("dec_other_func", bus32.o_muldiv_op, 0);
    @(negedge clk);

    // Narrow instance
    run16("w16_multu_max", F_MULTU, 16'hFFFF, 16'hFFFF, {16'hFFFE, 16'h0001});
    run16("w16_mult_m3x7", F_MULT, 16'hFFFD, 16'd7, {16'hFFFF, 16'hFFEB});
    run16("w16_div_m7d2", F_DIV, 16'hFFF9, 16'd2, {16'hFFFF, 16'hFFFD});
    run16("w16_div_ovf", F_DIV, 16'h8000, 16'hFFFF, {16'h0000, 16'h8000});

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
- Iterative multiply/divide unit with architectural HI/LO registers for the unpipelined MIPS core.
- Sits beside the ALU and is driven by the same opcode and func fields the ALU control decoder uses.
- Executes MULT/MULTU/DIV/DIVU as multi-cycle operations and MFHI/MFLO/MTHI/MTLO as single-cycle operations.
- Stalls the core through a busy/stall handshake.

Parameters:
- DATA_W, 32, operand, HI and LO width (must be ≥ 4 and even).
- CNT_W, $clog2(DATA_W)+1, width of the iteration counter (derived; do not override).

Ports:
- i_clk  input  1  core clock
- i_rst_n  input  1  reset, asynchronous, active-low
- i_valid  input  1  the instruction on i_aluOp/i_func is live this cycle
- i_aluOp  input  6  instruction opcode
- i_func  input  6  R-type function field
- i_op1  input  DATA_W  rs value
- i_op2  input  DATA_W  rt value
- i_flush  input  1  abort any in-flight operation (exception/eret)
- o_muldiv_op  output  1  decoded instruction belongs to this unit (combinational)
- o_stall  output  1  core must hold the current instruction
- o_busy  output  1  iteration in progress
- o_result  output  DATA_W  MFHI/MFLO read data
- o_hi  output  DATA_W  HI register
- o_lo  output  DATA_W  LO register

Behaviour:
- Decode: only when i_aluOp==6'h00. Function codes: MFHI 010000, MTHI 010001, MFLO 010010, MTLO 010011, MULT 011000, MULTU 011001, DIV 011010, DIVU 011011. o_muldiv_op=1 for these eight codes, else 0.
- Reset (async, i_rst_n=0): state=IDLE, HI=LO=0, counter=0. o_busy=0, o_stall=0, o_result=0. Reset mid-operation discards the operation.
- States and transitions:
  - IDLE: on i_valid & MULT/MULTU/DIV/DIVU, latch |op1|, |op2| (absolute values for signed ops, raw for unsigned), latch the result signs and the op kind, clear counter -> RUN.
  - RUN: one radix-2 step per cycle: shift-add for multiply, restoring subtract for divide. After DATA_W steps -> FIX.
  - FIX: apply sign correction, write HI/LO at the end of this cycle -> IDLE.
- Latency: start op accepted in cycle N; HI/LO valid from cycle N+DATA_W+2. o_busy=1 in RUN and FIX.
- Multiply result: {HI,LO} = 2*DATA_W-bit product; signed for MULT, unsigned for MULTU.
- Divide result: LO=quotient, HI=remainder. Quotient truncates toward zero; remainder takes the dividend's sign.
- Divide by zero: no exception. LO={DATA_W{1'b1}}, HI=i_op1 (raw), for both DIV and DIVU.
- Signed overflow (DIV of most-negative value by -1): LO=most-negative value, HI=0.
- o_stall = o_busy & i_valid & o_muldiv_op. Non-muldiv instructions proceed while the unit is busy.
  - The start instruction itself is not stalled.
  - A second start, or any MF/MT, while busy is held until IDLE. It is accepted in the cycle the state returns to IDLE.
- MTHI/MTLO: in IDLE with i_valid, write i_op1 into HI/LO at the clock edge.
- MFHI/MFLO: o_result = HI/LO combinationally while IDLE; otherwise o_result=0.
- i_flush: forces IDLE next cycle from RUN or FIX. HI/LO are left unchanged. i_flush has priority over a simultaneous start.
- Simultaneous FIX completion and a held MFHI: the MFHI is stalled this cycle and reads the new HI in the next cycle.

Decomposition:
- Shared package mips_isa_pkg holds the opcode/func localparams (OP_RTYPE, F_MULT, F_MULTU, F_DIV, F_DIVU, F_MFHI, F_MFLO, F_MTHI, F_MTLO), shared with the ALU control decoder.
- The package also holds the state encoding (IDLE/RUN/FIX).
- One sub-module, muldiv_core: the iterative datapath (shift registers, adder/subtractor, counter, sign fix).
- muldiv_unit keeps decode, handshake, HI/LO and flush control.

Test Plan:
- Reset mid-op: MULTU 0xFFFFFFFF*0xFFFFFFFF, then i_rst_n=0 at cycle 10 -> HI=LO=0, o_busy=0 immediately; after release, the unit is IDLE.
- MULT -3*7 (DATA_W=32) -> o_busy high for 33 cycles; then HI=0xFFFFFFFF, LO=0xFFFFFFEB; MFHI/MFLO return those values.
- DIV -7/2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF.
- DIVU 100/0 -> LO=0xFFFFFFFF, HI=100.
- DIV 0x80000000/-1 -> LO=0x80000000, HI=0.
- MFLO issued 1 cycle after MULTU 5*6 -> o_stall=1 until IDLE, then o_result=30. A non-muldiv i_func (ADD 100000) during busy -> o_stall=0.
- MTHI 0x1234 then i_flush during a DIV -> HI stays 0x1234, o_busy=0 next cycle. Rerun the suite with DATA_W=16: MULTU 0xFFFF*0xFFFF -> HI=0xFFFE, LO=0x0001.
